decoder_pulse_seq: RTL and testbench

DECODER_PULSE_SEQ -- requirements
Module: decoder_pulse_seq

---
 rtl/decoder_pulse_seq.sv | 113 +++++++++++
 tb/tb_decoder_pulse_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_pulse_seq.sv
// decoder_pulse_seq: registered binary decoder (one-hot or thermometer) whose
// output is held for HOLD cycles after each accepted request.
// Optional feature macro: DECODER_PULSE_SEQ_ERR_EN adds a sticky 'err' output
// that flags requests dropped because the block was not ready.
module decoder_pulse_seq #(
   parameter  int IN_W  = 4,
   parameter  int HOLD  = 1,
   parameter  int MODE  = 0,
   localparam int OUT_W = 2**IN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  decoder_in,
   output logic [OUT_W-1:0] decoder_out,
   output logic             out_valid,
   output logic             busy
`ifdef DECODER_PULSE_SEQ_ERR_EN
   ,
   output logic             err
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // The counter is loaded with the number of extra cycles after the first
   localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       hold_cnt;
   logic [7:0]       cnt_nxt;
   logic [OUT_W-1:0] dout_nxt;
   logic [OUT_W-1:0] decoded;
   logic             accept;

   // Decode the select code: single bit for one-hot, bits 0..code for thermometer
   always_comb begin
      decoded = '0;
      for (int i = 0; i < OUT_W; i++) begin
         if (MODE == 1) begin
            decoded[i] = (32'(i) <= 32'(decoder_in));
         end else begin
            decoded[i] = (32'(i) == 32'(decoder_in));
         end
      end
   end

   // Ready when idle or on the final cycle of a hold, so requests can chain
   always_comb begin
      in_ready = enable && ((state == ST_IDLE) || (hold_cnt == 8'd0));
      accept   = in_valid && in_ready;
   end

   // Next-state: accept loads a new decode, otherwise count down, abort or expire
   always_comb begin
      state_nxt = state;
      cnt_nxt   = hold_cnt;
      dout_nxt  = decoder_out;
      if (accept) begin
         state_nxt = ST_HOLD;
         cnt_nxt   = HOLD_LOAD;
         dout_nxt  = decoded;
      end else if (state == ST_HOLD) begin
         if (!enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 8'd0;
            dout_nxt  = '0;
         end else if (hold_cnt != 8'd0) begin
            cnt_nxt   = hold_cnt - 8'd1;
         end else begin
            state_nxt = ST_IDLE;
            dout_nxt  = '0;
         end
      end
   end

   // State, counter and output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         hold_cnt    <= 8'd0;
         decoder_out <= '0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= cnt_nxt;
         decoder_out <= dout_nxt;
      end
   end

   // The output is live exactly while a decode is being held
   always_comb begin
      busy      = (state == ST_HOLD);
      out_valid = busy;
   end

`ifdef DECODER_PULSE_SEQ_ERR_EN
   // Sticky flag for any request presented while the block could not take it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (in_valid && !in_ready) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_decoder_pulse_seq.sv
// Testbench for decoder_pulse_seq: three instances (HOLD/MODE variants) share
// one randomized stimulus stream; a reference model pushes expected outputs
// into per-instance queues and negedge monitors pop and compare.
module tb_decoder_pulse_seq;

   localparam int IN_W  = 4;
   localparam int OUT_W = 2**IN_W;
   localparam int NCFG  = 3;
   localparam int HOLD_CFG [NCFG] = '{1, 4, 8};
   localparam int MODE_CFG [NCFG] = '{0, 1, 0};

   logic            clk        = 1'b0;
   logic            rst_n      = 1'b0;
   logic            enable     = 1'b0;
   logic            in_valid   = 1'b0;
   logic [IN_W-1:0] decoder_in = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Reference decode: one-hot is 2^code, thermometer is 2^(code+1)-1
   function automatic logic [OUT_W-1:0] ref_decode(input int mode, input int code);
      if (mode == 0) return OUT_W'(64'd1 << code);
      else           return OUT_W'((64'd1 << (code + 1)) - 64'd1);
   endfunction

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      logic             in_ready;
      logic             out_valid;
      logic             busy;
      logic [OUT_W-1:0] decoder_out;
      logic [OUT_W-1:0] exp_q [$];
      logic             exp_v;
      logic [OUT_W-1:0] exp_d;
`ifdef DECODER_PULSE_SEQ_ERR_EN
      logic             err;
      logic             err_exp;
`endif

      decoder_pulse_seq #(
         .IN_W (IN_W),
         .HOLD (HOLD_CFG[g]),
         .MODE (MODE_CFG[g])
      ) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .enable      (enable),
         .in_valid    (in_valid),
         .in_ready    (in_ready),
         .decoder_in  (decoder_in),
         .decoder_out (decoder_out),
         .out_valid   (out_valid),
         .busy        (busy)
`ifdef DECODER_PULSE_SEQ_ERR_EN
         ,
         .err         (err)
`endif
      );

      // Model: a request is taken only when nothing is pending; it yields HOLD
      // output cycles. Dropping enable discards whatever is still pending.
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            exp_q.delete();
`ifdef DECODER_PULSE_SEQ_ERR_EN
            err_exp = 1'b0;
`endif
         end else begin
`ifdef DECODER_PULSE_SEQ_ERR_EN
            if (in_valid && !(enable && exp_q.size() == 0)) err_exp = 1'b1;
`endif
            if (in_valid && enable && exp_q.size() == 0) begin
               for (int k = 0; k < HOLD_CFG[g]; k++)
                  exp_q.push_back(ref_decode(MODE_CFG[g], int'(decoder_in)));
            end else if (!enable) begin
               exp_q.delete();
            end
         end
      end

      // Monitor: compare what the DUT presents against the scoreboard queue
      always @(negedge clk) begin
         if (rst_n) begin
            exp_v = (exp_q.size() != 0);
            check_output($sformatf("cfg%0d out_valid", g), 64'(out_valid), 64'(exp_v));
            check_output($sformatf("cfg%0d busy", g), 64'(busy), 64'(exp_v));
            if (exp_v) begin
               exp_d = exp_q.pop_front();
               check_output($sformatf("cfg%0d decoder_out", g), 64'(decoder_out), 64'(exp_d));
            end else begin
               check_output($sformatf("cfg%0d idle decoder_out", g), 64'(decoder_out), 64'd0);
            end
            check_output($sformatf("cfg%0d in_ready", g), 64'(in_ready),
                         64'(enable && exp_q.size() == 0));
`ifdef DECODER_PULSE_SEQ_ERR_EN
            check_output($sformatf("cfg%0d err", g), 64'(err), 64'(err_exp));
`endif
         end
      end
   end

   // Drive the inputs seen at the next rising edge
   task automatic apply_stimulus(input logic en, input logic vld, input logic [IN_W-1:0] code);
      @(posedge clk);
      #1;
      enable     = en;
      in_valid   = vld;
      decoder_in = code;
   endtask

   initial begin
      // Reset state
      #3;
      check_output("reset cfg0 out_valid", 64'(cfg[0].out_valid), 64'd0);
      check_output("reset cfg0 decoder_out", 64'(cfg[0].decoder_out), 64'd0);
      check_output("reset cfg2 busy", 64'(cfg[2].busy), 64'd0);
      #9 rst_n = 1'b1;

      // Single pulse, code 5
      apply_stimulus(1'b1, 1'b1, 4'h5);
      apply_stimulus(1'b1, 1'b0, 4'h0);
      @(negedge clk);
      #1;
      check_output("code5 onehot", 64'(cfg[0].decoder_out), 64'h0020);
      check_output("code5 thermo", 64'(cfg[1].decoder_out), 64'h003F);
      @(negedge clk);
      #1;
      check_output("code5 onehot expired", 64'(cfg[0].decoder_out), 64'h0000);
      repeat (8) apply_stimulus(1'b1, 1'b0, 4'h0);

      // Thermometer extremes
      apply_stimulus(1'b1, 1'b1, 4'h3);
      repeat (9) apply_stimulus(1'b1, 1'b0, 4'h0);
      apply_stimulus(1'b1, 1'b1, 4'hF);
      repeat (9) apply_stimulus(1'b1, 1'b0, 4'h0);

      // Back-to-back: code 2 then a continuous stream of code 9
      apply_stimulus(1'b1, 1'b1, 4'h2);
      repeat (10) apply_stimulus(1'b1, 1'b1, 4'h9);
      repeat (9) apply_stimulus(1'b1, 1'b0, 4'h0);

      // Abort via enable mid-hold
      apply_stimulus(1'b1, 1'b1, 4'hA);
      repeat (2) apply_stimulus(1'b1, 1'b0, 4'h0);
      apply_stimulus(1'b0, 1'b0, 4'h0);
      repeat (3) apply_stimulus(1'b1, 1'b0, 4'h0);

      // Asynchronous reset mid-hold, then accept on the first edge after release
      apply_stimulus(1'b1, 1'b1, 4'hA);
      repeat (2) apply_stimulus(1'b1, 1'b0, 4'h0);
      #2 rst_n = 1'b0;
      #1;
      check_output("async reset out_valid", 64'(cfg[2].out_valid), 64'd0);
      check_output("async reset decoder_out", 64'(cfg[2].decoder_out), 64'd0);
      check_output("async reset busy", 64'(cfg[1].busy), 64'd0);
      enable     = 1'b1;
      in_valid   = 1'b1;
      decoder_in = 4'h7;
      #3 rst_n = 1'b1;
      apply_stimulus(1'b1, 1'b0, 4'h0);
      @(negedge clk);
      #1;
      check_output("post-reset accept", 64'(cfg[2].decoder_out), 64'h0080);
      repeat (9) apply_stimulus(1'b1, 1'b0, 4'h0);

      // Randomized traffic
      repeat (600) begin
         apply_stimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) == 0),
                        IN_W'($urandom));
      end
      repeat (10) apply_stimulus(1'b1, 1'b0, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
